// File: rtl/riscv_pkg.sv
// Shared store-width encodings and store FSM state type.
package riscv_pkg;

    localparam logic [2:0] FUNCT3_B = 3'b000;
    localparam logic [2:0] FUNCT3_H = 3'b001;
    localparam logic [2:0] FUNCT3_W = 3'b010;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2
    } store_state_t;

    // Unshifted byte-enable pattern for a store width; zero for unsupported widths.
    function automatic logic [3:0] size_mask(input logic [2:0] funct3);
        case (funct3)
            FUNCT3_B: size_mask = 4'b0001;
            FUNCT3_H: size_mask = 4'b0011;
            FUNCT3_W: size_mask = 4'b1111;
            default:  size_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/store_align.sv
// Lane alignment for stores: size-masks the data, then shifts data and byte mask
// across a 64-bit (two-word) window according to the byte offset.
module store_align
    import riscv_pkg::*;
(
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  funct3,
    output logic [63:0] shifted,
    output logic [7:0]  mask,
    output logic        legal
);

    logic [31:0] data_d;
    logic [3:0]  base_d;

    always_comb begin
        base_d = size_mask(funct3);
        legal  = (base_d != 4'b0000);
        data_d = '0;
        case (funct3)
            FUNCT3_B: data_d = {24'b0, wdata[7:0]};
            FUNCT3_H: data_d = {16'b0, wdata[15:0]};
            FUNCT3_W: data_d = wdata;
            default:  data_d = '0;
        endcase
        shifted = {32'b0, data_d} << {addr, 3'b000};
        mask    = {4'b0, base_d} << addr;
    end

endmodule

// File: rtl/store_unit.sv
// Store unit: accepts one store at a time and issues one or two word-aligned
// write beats depending on whether the access straddles a word boundary.
module store_unit
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        done,
    output logic        illegal
);

    store_state_t state_q;
    logic         mem_valid_q;
    logic [31:0]  mem_addr_q;
    logic [31:0]  mem_wdata_q;
    logic [3:0]   mem_be_q;
    logic [31:0]  hi_wdata_q;
    logic [3:0]   hi_be_q;
    logic         done_q;
    logic         illegal_q;

    logic [63:0]  shifted_d;
    logic [7:0]   mask_d;
    logic         legal_d;
    logic [31:0]  beat2_addr_d;

    store_align u_align (
        .addr    (req_addr[1:0]),
        .wdata   (req_wdata),
        .funct3  (req_funct3),
        .shifted (shifted_d),
        .mask    (mask_d),
        .legal   (legal_d)
    );

    // Beat 1 address is already word-aligned, so +4 wraps modulo 2^32 for free.
    assign beat2_addr_d = mem_addr_q + 32'd4;

    // The request is captured already aligned: beat 1 goes straight to the bus
    // registers and beat 2 is parked in hi_*_q, so req_* is never looked at again.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            hi_wdata_q  <= '0;
            hi_be_q     <= '0;
            done_q      <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        if (legal_d) begin
                            state_q     <= FIRST;
                            mem_valid_q <= 1'b1;
                            mem_addr_q  <= {req_addr[31:2], 2'b00};
                            mem_be_q    <= mask_d[3:0];
                            mem_wdata_q <= shifted_d[31:0];
                            hi_be_q     <= mask_d[7:4];
                            hi_wdata_q  <= shifted_d[63:32];
                        end else begin
                            illegal_q <= 1'b1;
                        end
                    end
                end
                FIRST: begin
                    if (mem_ready) begin
                        if (hi_be_q != 4'b0000) begin
                            state_q     <= SECOND;
                            mem_addr_q  <= beat2_addr_d;
                            mem_be_q    <= hi_be_q;
                            mem_wdata_q <= hi_wdata_q;
                        end else begin
                            state_q     <= IDLE;
                            mem_valid_q <= 1'b0;
                            mem_addr_q  <= '0;
                            mem_be_q    <= '0;
                            mem_wdata_q <= '0;
                            done_q      <= 1'b1;
                        end
                    end
                end
                SECOND: begin
                    if (mem_ready) begin
                        state_q     <= IDLE;
                        mem_valid_q <= 1'b0;
                        mem_addr_q  <= '0;
                        mem_be_q    <= '0;
                        mem_wdata_q <= '0;
                        done_q      <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = (state_q == IDLE);
    assign mem_valid = mem_valid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign done      = done_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_store_unit.sv
// Directed and randomised stores against a byte-lane reference model, with a
// beat scoreboard that also drives per-beat mem_ready stalls.
module tb_store_unit;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        done;
    logic        illegal;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int unsigned stall;
    } beat_t;

    beat_t       exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int unsigned wait_ctr = 0;

    store_unit dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .done       (done),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Places each stored byte into its lane one at a time and queues the beats.
    function automatic int unsigned push_model(input logic [31:0] a, input logic [31:0] d,
                                               input logic [2:0] f3, input int unsigned stall);
        int unsigned size;
        int unsigned lane;
        int unsigned l;
        logic [3:0]  be0;
        logic [3:0]  be1;
        logic [31:0] w0;
        logic [31:0] w1;
        beat_t       b;
        size = (f3 == FUNCT3_B) ? 1 : (f3 == FUNCT3_H) ? 2 : 4;
        be0 = '0; be1 = '0; w0 = '0; w1 = '0;
        for (int unsigned k = 0; k < size; k++) begin
            lane = 32'(a[1:0]) + k;
            l    = lane % 4;
            if (lane < 4) begin
                be0[l] = 1'b1;
                w0[8*l +: 8] = d[8*k +: 8];
            end else begin
                be1[l] = 1'b1;
                w1[8*l +: 8] = d[8*k +: 8];
            end
        end
        b.addr = {a[31:2], 2'b00}; b.be = be0; b.wdata = w0; b.stall = stall;
        exp_q.push_back(b);
        if (be1 == 4'b0000) return 1;
        b.addr = {a[31:2], 2'b00} + 32'd4; b.be = be1; b.wdata = w1;
        exp_q.push_back(b);
        return 2;
    endfunction

    // Bus monitor and ready driver: compares every presented beat (stalled or not)
    // against the scoreboard head and pops it on the cycle it will be accepted.
    initial begin
        mem_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (done || illegal)
                chk("done_illegal_exclusive", {31'b0, done && illegal}, 32'd0);
            if (!rst && mem_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", {31'b0, mem_valid}, 32'd0);
                    mem_ready = 1'b1;
                end else begin
                    chk("beat_addr", mem_addr, exp_q[0].addr);
                    chk("beat_be", {28'b0, mem_be}, {28'b0, exp_q[0].be});
                    chk("beat_wdata", mem_wdata, exp_q[0].wdata);
                    if (wait_ctr < exp_q[0].stall) begin
                        mem_ready = 1'b0;
                        wait_ctr++;
                    end else begin
                        mem_ready = 1'b1;
                        wait_ctr  = 0;
                        void'(exp_q.pop_front());
                    end
                end
            end else begin
                mem_ready = 1'b1;
            end
        end
    end

    task automatic store(input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] f3, input int unsigned stall);
        int unsigned beats;
        bit          seen;
        beats = push_model(a, d, f3, stall);
        chk("ready_before_req", {31'b0, req_ready}, 32'd1);
        req_addr = a; req_wdata = d; req_funct3 = f3; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_addr   = $urandom;
        req_wdata  = $urandom;
        req_funct3 = 3'($urandom);
        seen = 1'b0;
        for (int unsigned k = 1; k <= 200 && !seen; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                chk("done_latency", k, 1 + beats * (stall + 1));
                chk("ready_at_done", {31'b0, req_ready}, 32'd1);
                chk("scoreboard_drained", exp_q.size(), 32'd0);
            end
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        chk("done_single_pulse", {31'b0, done}, 32'd0);
    endtask

    task automatic store_illegal(input logic [2:0] f3);
        chk("ready_before_illegal", {31'b0, req_ready}, 32'd1);
        req_addr = 32'h0000_5000; req_wdata = 32'h1234_5678; req_funct3 = f3; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("illegal_pulse", {31'b0, illegal}, 32'd1);
        chk("illegal_no_valid", {31'b0, mem_valid}, 32'd0);
        chk("illegal_stays_idle", {31'b0, req_ready}, 32'd1);
        chk("illegal_no_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        chk("illegal_one_cycle", {31'b0, illegal}, 32'd0);
        chk("illegal_still_no_valid", {31'b0, mem_valid}, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
        chk({tag, "_mem_valid"}, {31'b0, mem_valid}, 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_mem_be"}, {28'b0, mem_be}, 32'd0);
        chk({tag, "_done"}, {31'b0, done}, 32'd0);
        chk({tag, "_illegal"}, {31'b0, illegal}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_funct3 = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        check_reset_state("post_reset");

        store(32'h0000_1003, 32'hAABB_CCDD, FUNCT3_B, 0);
        store(32'h0000_2002, 32'h1234_5678, FUNCT3_H, 0);
        store(32'h0000_3001, 32'h1122_3344, FUNCT3_W, 0);
        store(32'h0000_4003, 32'h0000_BEEF, FUNCT3_H, 3);
        store(32'hFFFF_FFFE, 32'hCAFE_F00D, FUNCT3_W, 0);
        store(32'h0000_0010, 32'hDEAD_BEEF, FUNCT3_W, 1);
        store(32'h0000_0020, 32'h0000_00A5, FUNCT3_B, 0);
        store_illegal(3'b011);
        store_illegal(3'b111);
        for (int i = 0; i < 10; i++)
            store($urandom, $urandom, 3'($urandom_range(0, 2)), $urandom_range(0, 2));

        // Reset while the second beat of a split store is stalled.
        void'(push_model(32'h0000_4003, 32'h0000_BEEF, FUNCT3_H, 0));
        exp_q[exp_q.size() - 1].stall = 1000;
        req_addr = 32'h0000_4003; req_wdata = 32'h0000_BEEF; req_funct3 = FUNCT3_H; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (mem_valid && mem_be == 4'b0001) found = 1'b1;
        end
        chk("reached_stalled_second", {31'b0, found}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        req_valid = 1'b1; req_addr = 32'h0000_6001; req_wdata = 32'h5555_AAAA; req_funct3 = FUNCT3_W;
        @(posedge clk); #1;
        chk("rst_abandon_valid", {31'b0, mem_valid}, 32'd0);
        chk("rst_abandon_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;
        chk("rst_overrides_req", {31'b0, mem_valid}, 32'd0);
        rst = 1'b0; req_valid = 1'b0;
        exp_q.delete();
        wait_ctr = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("rst_no_done", {31'b0, done}, 32'd0);
            chk("rst_no_beat", {31'b0, mem_valid}, 32'd0);
        end
        @(posedge clk); #1;
        store(32'h0000_7001, 32'h0000_00C3, FUNCT3_B, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/store_unit.md
STORE_UNIT -- requirements
Module: store_unit

Interface
REQ-001 The block SHALL have these ports: clk, input, 1, sole clock; all state updates on the rising edge.
REQ-002 The block SHALL have these ports: rst, input, 1, synchronous active-high reset.
REQ-003 The block SHALL have these ports: req_valid, input, 1, store request from the pipeline.
REQ-004 The block SHALL have these ports: req_ready, output, 1, block can accept a request.
REQ-005 The block SHALL have these ports: req_addr, input, 32, byte address computed by the ALU.
REQ-006 The block SHALL have these ports: req_wdata, input, 32, store data; bytes used from the LSB up.
REQ-007 The block SHALL have these ports: req_funct3, input, 3, store width: FUNCT3_B (000), FUNCT3_H (001), FUNCT3_W (010).
REQ-008 The block SHALL have these ports: mem_valid, output, 1, data-memory write request.
REQ-009 The block SHALL have these ports: mem_ready, input, 1, memory accepts the beat.
REQ-010 The block SHALL have these ports: mem_addr, output, 32, word-aligned address with bits [1:0]=00.
REQ-011 The block SHALL have these ports: mem_wdata, output, 32, lane-aligned write data.
REQ-012 The block SHALL have these ports: mem_be, output, 4, byte enables; bit i enables lane [8i+7:8i].
REQ-013 The block SHALL have these ports: done, output, 1, one-cycle pulse when a store completes.
REQ-014 The block SHALL have these ports: illegal, output, 1, one-cycle pulse when req_funct3 is unsupported.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, FIRST, SECOND.
REQ-016 req_ready SHALL equal 1 only in IDLE; a request is accepted on a clock edge where req_valid && req_ready.
REQ-017 On acceptance, the block SHALL register the address, data and funct3; later changes on req_* SHALL have no effect.
REQ-018 The block SHALL form a 64-bit shifted data value {32'b0, wdata} << (8*addr[1:0]).
REQ-019 The block SHALL form an 8-bit mask (1, 3 or F for B/H/W) << addr[1:0].
REQ-020 The size SHALL be masked before shifting: B keeps wdata[7:0], H keeps wdata[15:0].
REQ-021 Beat 1 SHALL use mem_addr = {addr[31:2],2'b00}, mem_be = mask[3:0], mem_wdata = shifted[31:0].
REQ-022 A beat 2 SHALL be needed iff mask[7:4] != 0.
REQ-023 Beat 2 SHALL use mem_addr = {addr[31:2],2'b00} + 4, wrapping modulo 2^32, with mem_be = mask[7:4] and mem_wdata = shifted[63:32].
REQ-024 Lanes whose mem_be bit is 0 SHALL be driven to 8'h00.
REQ-025 Transition IDLE->FIRST SHALL occur on acceptance of a legal funct3; mem_valid=1 from the next cycle.
REQ-026 In FIRST and SECOND, mem_valid, mem_addr, mem_wdata and mem_be SHALL stay stable until a cycle with mem_ready=1.
REQ-027 On the beat-1 handshake, the FSM SHALL go FIRST->SECOND if beat 2 is needed, else FIRST->IDLE.
REQ-028 On the beat-2 handshake, the FSM SHALL go SECOND->IDLE.
REQ-029 done SHALL be a registered pulse, high in the cycle after the final handshake, coinciding with req_ready=1.
REQ-030 Minimum latency SHALL be: acceptance at edge N, aligned beat handshake in cycle N+1, done in cycle N+2; split store done in N+3.
REQ-031 An unsupported funct3 (011..111) SHALL cause no bus traffic, illegal=1 for one cycle after acceptance, and the FSM SHALL remain in IDLE.
REQ-032 mem_ready while mem_valid=0 SHALL be ignored.
REQ-033 done and illegal SHALL never be asserted in the same cycle.

Reset
REQ-034 After rst, the block SHALL be in state IDLE with req_ready=1, mem_valid=0, mem_addr=0, mem_wdata=0, mem_be=0, done=0 and illegal=0.
REQ-035 rst SHALL override all other inputs.
REQ-036 rst asserted mid-store, including in SECOND while stalled, SHALL abandon the store: no further beat and no done pulse.

Structure
REQ-037 FUNCT3_B/H/W and the state enum store_state_t SHALL live in riscv_pkg.
REQ-038 The shift/mask logic SHALL be one combinational sub-module, store_align (inputs addr[1:0], wdata, funct3; outputs shifted[63:0], mask[7:0], legal).

Verification
REQ-039 SB at addr 0x1003, data 0xAABBCCDD -> one beat: addr 0x1000, be 1000, wdata 0xDD000000; done 2 cycles after acceptance.
REQ-040 SH at addr 0x2002, data 0x12345678 -> one beat: addr 0x2000, be 1100, wdata 0x56780000.
REQ-041 SW at addr 0x3001, data 0x11223344 -> beat 1: addr 0x3000, be 1110, wdata 0x22334400; beat 2: addr 0x3004, be 0001, wdata 0x00000011.
REQ-042 SH at addr 0x4003, data 0xBEEF, mem_ready low for 3 cycles per beat -> outputs stable while stalled; beat 1: 0x4000 / 1000 / 0xEF000000; beat 2: 0x4004 / 0001 / 0x000000BE.
REQ-043 SW at addr 0xFFFFFFFE -> beat 2 addr 0x00000000, be 0011; funct3=011 -> illegal pulse, mem_valid never 1.
REQ-044 rst during a stalled SECOND -> mem_valid=0 and req_ready=1 after the edge, no done pulse.
